// File: rtl/bus_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bus_arb_pkg
//  Description : Shared types and constants for the four-requester
//                round-robin bus arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package bus_arb_pkg;

  // Arbiter FSM: IDLE with no owner, BUSY while a requester holds the bus
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  localparam int N_REQ = 4;
  localparam int SEL_W = 2;

endpackage
`default_nettype wire

// File: rtl/MUX_4_32.sv
`default_nettype none
// ============================================================================
//  Module      : MUX_4_32
//  Description : 4:1 data multiplexer, 32 bits wide by default.
//  Revision    : 1.0 - initial release
// ============================================================================
module MUX_4_32 #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [WIDTH-1:0] in3,
  input  logic [1:0]       sel,
  output logic [WIDTH-1:0] y
);

  // Plain select; every sel value is covered so no latch is possible
  always_comb begin
    case (sel)
      2'd0:    y = in0;
      2'd1:    y = in1;
      2'd2:    y = in2;
      default: y = in3;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/rr_pick4.sv
`default_nettype none
// ============================================================================
//  Module      : rr_pick4
//  Description : Combinational round-robin picker. Returns the first set
//                request scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4).
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_pick4
  import bus_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] ptr,
  output logic             any,
  output logic [SEL_W-1:0] idx
);

  // Scan from the farthest slot back to ptr so the nearest hit overwrites
  always_comb begin
    any = |req;
    idx = ptr;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (req[ptr + SEL_W'(k)]) begin
        idx = ptr + SEL_W'(k);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/bus_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : bus_rr_arbiter
//  Description : Four-requester round-robin arbiter for a shared result bus.
//                The winner owns the bus for a burst that ends on last,
//                on the hold limit, or when it withdraws its request.
//  Revision    : 1.0 - initial release
// ============================================================================
module bus_rr_arbiter
  import bus_arb_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int MAX_HOLD = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [3:0]        req,
  input  logic [3:0]        last,
  input  logic [DATA_W-1:0] data0,
  input  logic [DATA_W-1:0] data1,
  input  logic [DATA_W-1:0] data2,
  input  logic [DATA_W-1:0] data3,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        out_sel,
  output logic [3:0]        grant,
  output logic [3:0]        ack
);

  localparam int              CNT_W      = $clog2(MAX_HOLD + 1);
  localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(MAX_HOLD - 1);

  arb_state_e        state_q, state_d;
  logic [SEL_W-1:0]  owner_q, owner_d;
  logic [SEL_W-1:0]  ptr_q,   ptr_d;
  logic [CNT_W-1:0]  cnt_q,   cnt_d;

  logic              w_beat;
  logic              w_release;
  logic [SEL_W-1:0]  w_pick_ptr;
  logic              w_pick_any;
  logic [SEL_W-1:0]  w_pick_idx;
  logic [DATA_W-1:0] w_mux_data;

  // While busy the picker only matters on release, where the new pointer is
  // owner+1; feeding that directly gives a same-cycle handover with the old
  // owner at lowest priority.
  assign w_pick_ptr = (state_q == BUSY) ? (owner_q + 1'b1) : ptr_q;

  rr_pick4 u_pick (
    .req (req),
    .ptr (w_pick_ptr),
    .any (w_pick_any),
    .idx (w_pick_idx)
  );

  // State register, cleared asynchronously so outputs drop at once
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      owner_q <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state, release detection and stream handshake
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    grant     = '0;
    out_valid = 1'b0;
    w_beat    = 1'b0;
    w_release = 1'b0;
    case (state_q)
      IDLE: begin
        if (w_pick_any) begin
          owner_d = w_pick_idx;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        grant[owner_q] = 1'b1;
        out_valid      = req[owner_q];
        w_beat         = req[owner_q] & out_ready;
        // last and hold limit on the same beat collapse into one release
        w_release      = ~req[owner_q]
                       | (w_beat & (last[owner_q] | (cnt_q == c_cnt_last)));
        if (w_release) begin
          ptr_d = owner_q + 1'b1;
          cnt_d = '0;
          if (w_pick_any) begin
            owner_d = w_pick_idx;
          end else begin
            state_d = IDLE;
          end
        end else if (w_beat) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  MUX_4_32 #(
    .WIDTH (DATA_W)
  ) u_mux (
    .in0 (data0),
    .in1 (data1),
    .in2 (data2),
    .in3 (data3),
    .sel (owner_q),
    .y   (w_mux_data)
  );

  assign out_sel  = owner_q;
  assign out_data = (grant == 4'b0000) ? '0 : w_mux_data;
  assign ack      = grant & {4{w_beat}};

endmodule
`default_nettype wire
